// File: rtl/test_sig_monitor.sv
// test_sig_monitor: snoops bus writes for signature capture, halt pass/fail detection and cycle timeout
module test_sig_monitor #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] SIG_ADDR   = 32'h8E00_0000,
  parameter logic [ADDR_W-1:0] HALT_ADDR  = 32'h8F00_0000,
  parameter logic [DATA_W-1:0] PASS_CODE  = 1,
  parameter int                FIFO_DEPTH = 8,
  parameter int                CYC_W      = 32,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_wr_i,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic [DATA_W-1:0] bus_wdata_i,
  input  logic [CYC_W-1:0]  max_cycles_i,
  output logic              sig_valid_o,
  output logic [DATA_W-1:0] sig_data_o,
  input  logic              sig_ready_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic              overflow_o,
  output logic [DATA_W-1:0] halt_code_o,
  output logic [CYC_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  sig_count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {RUN, HALTED, TIMED_OUT} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic run, sig_wr, halt_wr, to_hit, full, pop, push;
  assign run         = state == RUN;
  assign done_o      = !run;
  assign timeout_o   = state == TIMED_OUT;
  assign sig_wr      = run & bus_wr_i & (bus_addr_i == SIG_ADDR);
  assign halt_wr     = run & bus_wr_i & (bus_addr_i == HALT_ADDR);
  assign to_hit      = run & (max_cycles_i != '0) & (cycle_cnt_o == max_cycles_i - CYC_W'(1));
  assign full        = (wp[AW] != rp[AW]) & (wp[AW-1:0] == rp[AW-1:0]);
  assign sig_valid_o = wp != rp;
  assign sig_data_o  = sig_valid_o ? mem[rp[AW-1:0]] : '0;
  assign pop         = sig_valid_o & sig_ready_i;
  assign push        = sig_wr & (!full | pop);
  // state register; terminal states hold until reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nxt;
  // halt takes priority over a coincident timeout
  always_comb begin
    state_nxt = state;
    state_nxt = halt_wr ? HALTED : to_hit ? TIMED_OUT : state;
  end
  // signature storage; contents need no reset since reads are gated by valid
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= bus_wdata_i;
  // pointers, counters and sticky result flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp          <= '0;
      rp          <= '0;
      overflow_o  <= 1'b0;
      pass_o      <= 1'b0;
      halt_code_o <= '0;
      cycle_cnt_o <= '0;
      sig_count_o <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
      if (sig_wr && full && !pop) overflow_o <= 1'b1;
      if (push && !(&sig_count_o)) sig_count_o <= sig_count_o + CNT_W'(1);
      if (run && !(&cycle_cnt_o)) cycle_cnt_o <= cycle_cnt_o + CYC_W'(1);
      if (halt_wr) begin
        halt_code_o <= bus_wdata_i;
        pass_o      <= bus_wdata_i == PASS_CODE;
      end
    end
endmodule

// File: tb/tb_test_sig_monitor.sv
// tb_test_sig_monitor: directed checks of capture, drain, overflow, halt and timeout
module tb_test_sig_monitor;
  localparam logic [31:0] SIG  = 32'h8E00_0000;
  localparam logic [31:0] HALT = 32'h8F00_0000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_wr_i = 1'b0;
  logic [31:0] bus_addr_i = '0;
  logic [31:0] bus_wdata_i = '0;
  logic [31:0] max_cycles_i = '0;
  logic        sig_ready_i = 1'b0;
  logic        sig_valid_o, done_o, pass_o, timeout_o, overflow_o;
  logic [31:0] sig_data_o, halt_code_o, cycle_cnt_o;
  logic [15:0] sig_count_o;
  int n_cmp = 0;
  int n_err = 0;
  test_sig_monitor dut (
    .clk(clk), .rst_n(rst_n), .bus_wr_i(bus_wr_i), .bus_addr_i(bus_addr_i),
    .bus_wdata_i(bus_wdata_i), .max_cycles_i(max_cycles_i), .sig_valid_o(sig_valid_o),
    .sig_data_o(sig_data_o), .sig_ready_i(sig_ready_i), .done_o(done_o), .pass_o(pass_o),
    .timeout_o(timeout_o), .overflow_o(overflow_o), .halt_code_o(halt_code_o),
    .cycle_cnt_o(cycle_cnt_o), .sig_count_o(sig_count_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_wr_i = 1'b1;
    bus_addr_i = a;
    bus_wdata_i = d;
    step();
    bus_wr_i = 1'b0;
  endtask
  task automatic do_reset(input logic [31:0] m);
    rst_n = 1'b0;
    sig_ready_i = 1'b0;
    bus_wr_i = 1'b0;
    max_cycles_i = m;
    step();
    step();
    rst_n = 1'b1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, sig_valid_o, 0);
    chk({tag, "_data"}, sig_data_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_pass"}, pass_o, 0);
    chk({tag, "_timeout"}, timeout_o, 0);
    chk({tag, "_ovf"}, overflow_o, 0);
    chk({tag, "_code"}, halt_code_o, 0);
    chk({tag, "_cyc"}, cycle_cnt_o, 0);
    chk({tag, "_cnt"}, sig_count_o, 0);
  endtask
  initial begin
    // reset state
    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;
    // capture then drain
    wr(SIG, 32'h11);
    wr(SIG, 32'h22);
    wr(SIG, 32'h33);
    chk("cap_cnt", sig_count_o, 3);
    chk("cap_valid", sig_valid_o, 1);
    chk("cap_head", sig_data_o, 32'h11);
    step();
    chk("cap_stable", sig_data_o, 32'h11);
    sig_ready_i = 1'b1;
    step();
    chk("drain_1", sig_data_o, 32'h22);
    step();
    chk("drain_2", sig_data_o, 32'h33);
    step();
    chk("drain_empty", sig_valid_o, 0);
    chk("other_addr_none", overflow_o, 0);
    // overflow then wrap
    do_reset(0);
    for (int i = 1; i <= 9; i++) wr(SIG, i);
    chk("ovf_cnt", sig_count_o, 8);
    chk("ovf_flag", overflow_o, 1);
    sig_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_drain_%0d", i), sig_data_o, i);
      step();
    end
    chk("ovf_empty", sig_valid_o, 0);
    sig_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) wr(SIG, 32'h20 + i);
    chk("wrap_cnt", sig_count_o, 16);
    sig_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wrap_drain_%0d", i), sig_data_o, 32'h20 + i);
      step();
    end
    chk("wrap_empty", sig_valid_o, 0);
    // push and pop on a full FIFO
    do_reset(0);
    for (int i = 0; i < 8; i++) wr(SIG, 32'h30 + i);
    sig_ready_i = 1'b1;
    wr(SIG, 32'hAA);
    chk("pp_ovf", overflow_o, 0);
    chk("pp_cnt", sig_count_o, 9);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("pp_drain_%0d", i), sig_data_o, 32'h30 + i);
      step();
    end
    chk("pp_last", sig_data_o, 32'hAA);
    step();
    chk("pp_empty", sig_valid_o, 0);
    // halt with pass code
    do_reset(0);
    step();
    step();
    wr(HALT, 1);
    chk("halt_done", done_o, 1);
    chk("halt_pass", pass_o, 1);
    chk("halt_code", halt_code_o, 1);
    chk("halt_cyc", cycle_cnt_o, 3);
    chk("halt_to", timeout_o, 0);
    step();
    wr(HALT, 3);
    wr(SIG, 32'h55);
    chk("post_code", halt_code_o, 1);
    chk("post_pass", pass_o, 1);
    chk("post_cyc", cycle_cnt_o, 3);
    chk("post_cnt", sig_count_o, 0);
    chk("post_valid", sig_valid_o, 0);
    chk("post_ovf", overflow_o, 0);
    // halt with fail code
    do_reset(0);
    wr(HALT, 32'hDEAD);
    chk("fail_done", done_o, 1);
    chk("fail_pass", pass_o, 0);
    chk("fail_code", halt_code_o, 32'hDEAD);
    // timeout
    do_reset(5);
    for (int i = 0; i < 4; i++) step();
    chk("to_pre_cyc", cycle_cnt_o, 4);
    chk("to_pre_done", done_o, 0);
    step();
    chk("to_done", done_o, 1);
    chk("to_flag", timeout_o, 1);
    chk("to_cyc", cycle_cnt_o, 5);
    chk("to_pass", pass_o, 0);
    step();
    step();
    chk("to_frozen", cycle_cnt_o, 5);
    // halt and timeout on the same edge
    do_reset(5);
    for (int i = 0; i < 4; i++) step();
    wr(HALT, 1);
    chk("tie_done", done_o, 1);
    chk("tie_to", timeout_o, 0);
    chk("tie_pass", pass_o, 1);
    chk("tie_cyc", cycle_cnt_o, 5);
    // asynchronous reset mid-run
    do_reset(0);
    wr(SIG, 32'h77);
    wr(HALT, 32'h9);
    chk("mid_pre_done", done_o, 1);
    chk("mid_pre_valid", sig_valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    rst_n = 1'b1;
    step();
    chk("mid_first_cyc", cycle_cnt_o, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
